fpga_gearbox_tx: RTL
====================

Name: fpga_gearbox_tx

Overview:
- Parametrised multi-lane transmit gearbox.
- Converts IN_W-bit parallel words per lane into OUT_W-bit output slices per lane, LSB-first, in a single clock domain.
- Sits upstream of the per-lane serializer primitives. Example: 10-bit symbols feed 8:1 serializers when IN_W=10, OUT_W=8.
- Adds handshake back-pressure, idle fill, underflow detection and optional link training; the plain 10:1 serializer has none of these.

Parameters:
- NUM_LANES, 4, number of independent lanes sharing one handshake.
- IN_W, 10, input bits per lane per accepted word.
- OUT_W, 8, output bits per lane per cycle; OUT_W <= IN_W.
- IDLE_PAT, 8'h00, OUT_W-bit slice driven per lane when no data is available.
- TRAIN_PAT, 8'hF0, OUT_W-bit slice driven per lane during training (optional feature).

Ports:
- clk, in, 1, single clock.
- rst, in, 1, synchronous active-high reset.
- s_valid, in, 1, input word valid.
- s_ready, out, 1, gearbox can accept a word this cycle.
- s_data, in, NUM_LANES*IN_W, lane k occupies bits [k*IN_W +: IN_W].
- train, in, 1, training request (optional feature).
- m_valid, out, 1, m_data carries payload bits.
- m_data, out, NUM_LANES*OUT_W, lane k occupies bits [k*OUT_W +: OUT_W]; bit 0 is transmitted first.
- underflow, out, 1, sticky underflow flag.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Buffer: one shift buffer per lane, BUF_W = IN_W+OUT_W bits. One shared fill counter, width $clog2(BUF_W+1), identical for all lanes.
- Per-cycle accounting:
  - consume = (fill >= OUT_W).
  - fill_after = fill - (consume ? OUT_W : 0).
  - s_ready = (fill_after + IN_W <= BUF_W). s_ready is combinational from registered fill only; it never depends on s_valid.
  - Accept when s_valid && s_ready. The new word is appended at bit position fill_after of each lane buffer; the buffer shifts right by OUT_W on consume.
  - Consume and accept in the same cycle are legal and both take effect: fill_next = fill_after + IN_W.
- Output:
  - m_data and m_valid are registered.
  - On consume: m_data = buffer[OUT_W-1:0] per lane, m_valid=1.
  - Otherwise: m_data = IDLE_PAT per lane, m_valid=0.
- Latency: word accepted at cycle t produces its first slice on m_data at t+2, provided the buffer holds >= OUT_W bits at t+1.
- Bit order is preserved exactly across word boundaries (LSB-first concatenation). No bits are dropped or duplicated.
- Priming and underflow:
  - A primed flag sets on the first consume.
  - Once primed, any cycle with fill < OUT_W sets underflow (sticky until rst) and drives idle.
  - Residual bits stay in the buffer and are emitted once enough data has been appended.
- Reset values: fill=0, buffers=0, m_valid=0, m_data=IDLE_PAT on all lanes, underflow=0, primed=0.
- Reset mid-stream: partial-word residue is discarded. s_ready is 1 in the first cycle after rst deasserts.
- s_data is sampled only on accept. Holding s_valid high with s_ready low causes no state change.

Optional Feature:
- Macro: FPGA_GEARBOX_TRAIN_EN.
- Defined:
  - While train=1: m_data = TRAIN_PAT on all lanes, m_valid=0, s_ready=0, fill forced to 0 (buffer flushed), primed cleared, underflow not set.
  - Takes effect on m_data the cycle after train is sampled high.
  - On train deassert, behaves as just out of reset, except underflow keeps its value.
- Not defined: train is ignored and no training logic is synthesised.

Decomposition:
- Shared package fpga_gearbox_pkg holds:
  - BUF_W and fill-width helper functions.
  - Default IDLE_PAT and TRAIN_PAT constants.
  - A typedef for the per-lane buffer vector.
- One natural sub-module: fpga_gearbox_lane. It holds one lane's buffer append/shift datapath and takes fill_after, accept and consume from the shared control in the top.
- Top holds the fill counter, handshake, primed/underflow and training control.

Test Plan:
- Basic order: NUM_LANES=1, IN_W=10, OUT_W=8. Push 10'h3FF, 10'h000, 10'h3FF, 10'h000 back-to-back. Expect m_valid slices 8'hFF, 8'h03, 8'hF0, 8'h3F, 8'h00, then idle 8'h00 with m_valid=0 and underflow=1.
- Back-pressure: hold s_valid=1 continuously with incrementing words. Expect s_ready to deassert exactly when fill_after > 8, no accepted word lost, output stream equal to reference bit-concatenation, underflow=0.
- Multi-lane: 4 lanes with distinct words (lane k = 10'h100+k). Expect each lane's slices independent and correctly ordered, with common m_valid timing.
- Reset mid-stream: assert rst after 3 accepted words while fill=6. Expect next cycle m_valid=0, m_data=IDLE_PAT, underflow=0, s_ready=1; first post-reset word emerges at t+2.
- Underflow recovery: starve input for 2 cycles after priming. Expect idle slices, underflow stays 1, then correct resumption with the residual bits first.
- Training (FPGA_GEARBOX_TRAIN_EN): assert train for 5 cycles mid-stream. Expect 5 cycles of 8'hF0 on all lanes with s_ready=0; after release fill=0 and normal data resumes.

Source files
------------

// File: rtl/fpga_gearbox_pkg.sv
// Shared geometry helpers, default patterns and buffer typedef for the TX gearbox.
// Training support is selected with the FPGA_GEARBOX_TRAIN_EN macro.
package fpga_gearbox_pkg;

    localparam int DEF_IN_W  = 10;
    localparam int DEF_OUT_W = 8;

    localparam logic [7:0] IDLE_PAT_DEF  = 8'h00;
    localparam logic [7:0] TRAIN_PAT_DEF = 8'hF0;

    function automatic int buf_w(input int in_w, input int out_w);
        return in_w + out_w;
    endfunction

    function automatic int fill_w(input int in_w, input int out_w);
        return $clog2(in_w + out_w + 1);
    endfunction

    typedef logic [buf_w(DEF_IN_W, DEF_OUT_W)-1:0] lane_buf_t;

endpackage

// File: rtl/fpga_gearbox_lane.sv
// One lane's shift buffer: appends accepted words at fill_after, shifts out OUT_W on consume.
// Control (fill, accept, consume, flush) comes from the shared top-level logic.
module fpga_gearbox_lane
    import fpga_gearbox_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int FILL_W = fill_w(DEF_IN_W, DEF_OUT_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              accept,
    input  logic              consume,
    input  logic [FILL_W-1:0] fill_after,
    input  logic [IN_W-1:0]   word,
    output logic [OUT_W-1:0]  head
);

    localparam int BUF_W = buf_w(IN_W, OUT_W);

    logic [BUF_W-1:0] sh;
    logic [BUF_W-1:0] shifted;
    logic [BUF_W-1:0] sh_next;

    // Drop the consumed slice, then place a new word just above the residue.
    always_comb begin
        shifted = consume ? (sh >> OUT_W) : sh;
        sh_next = shifted;
        if (accept) begin
            sh_next = shifted | ({{OUT_W{1'b0}}, word} << fill_after);
        end
    end

    // Buffer register; bits above the fill level are always kept at zero.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            sh <= '0;
        end else begin
            sh <= sh_next;
        end
    end

    assign head = sh[OUT_W-1:0];

endmodule

// File: rtl/fpga_gearbox_tx.sv
// Multi-lane IN_W-to-OUT_W transmit gearbox with handshake, idle fill and underflow flag.
// Optional link training is compiled in when FPGA_GEARBOX_TRAIN_EN is defined.
module fpga_gearbox_tx
    import fpga_gearbox_pkg::*;
#(
    parameter int NUM_LANES             = 4,
    parameter int IN_W                  = DEF_IN_W,
    parameter int OUT_W                 = DEF_OUT_W,
    parameter logic [OUT_W-1:0] IDLE_PAT  = OUT_W'(IDLE_PAT_DEF),
    parameter logic [OUT_W-1:0] TRAIN_PAT = OUT_W'(TRAIN_PAT_DEF)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [NUM_LANES*IN_W-1:0]  s_data,
    input  logic                       train,
    output logic                       m_valid,
    output logic [NUM_LANES*OUT_W-1:0] m_data,
    output logic                       underflow
);

    localparam int BUF_W = buf_w(IN_W, OUT_W);
    localparam int FW    = fill_w(IN_W, OUT_W);

    logic [FW-1:0] fill;
    logic [FW-1:0] fill_after;
    logic [FW-1:0] fill_next;
    logic          consume;
    logic          accept;
    logic          training;
    logic          primed;
    logic [NUM_LANES*OUT_W-1:0] heads;

`ifdef FPGA_GEARBOX_TRAIN_EN
    assign training = train;
`else
    logic unused_train_cfg;
    assign training         = 1'b0;
    assign unused_train_cfg = train ^ (^TRAIN_PAT);
`endif

    // Shared fill accounting and handshake, derived from registered fill only.
    always_comb begin
        consume    = (fill >= FW'(OUT_W));
        fill_after = consume ? (fill - FW'(OUT_W)) : fill;
        s_ready    = !training &&
                     (({1'b0, fill_after} + (FW+1)'(IN_W)) <= (FW+1)'(BUF_W));
        accept     = s_valid && s_ready;
        fill_next  = accept ? (fill_after + FW'(IN_W)) : fill_after;
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        fpga_gearbox_lane #(
            .IN_W   (IN_W),
            .OUT_W  (OUT_W),
            .FILL_W (FW)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .flush      (training),
            .accept     (accept),
            .consume    (consume),
            .fill_after (fill_after),
            .word       (s_data[k*IN_W +: IN_W]),
            .head       (heads[k*OUT_W +: OUT_W])
        );
    end

    // Fill counter, registered output slice, priming and sticky underflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill      <= '0;
            primed    <= 1'b0;
            underflow <= 1'b0;
            m_valid   <= 1'b0;
            m_data    <= {NUM_LANES{IDLE_PAT}};
        end else if (training) begin
            fill      <= '0;
            primed    <= 1'b0;
            m_valid   <= 1'b0;
            m_data    <= {NUM_LANES{TRAIN_PAT}};
        end else begin
            fill    <= fill_next;
            m_valid <= consume;
            m_data  <= consume ? heads : {NUM_LANES{IDLE_PAT}};
            if (consume) begin
                primed <= 1'b1;
            end
            if (primed && !consume) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule
